// File: rtl/avm_gpio_initiator.sv
// ----------------------------------------------------------------------------
// avm_gpio_initiator
//
// Avalon-MM initiator for the PIO-style GPIO register slave of the pcmplay
// core. The slave has a data register at address 0 and a direction register
// at address 1, a fixed read latency and no waitrequest.
//
// Local control logic issues single read/write commands over a valid/ready
// handshake; read responses return as a one-cycle strobe with held data.
// When no command is in flight the block polls address 0 every
// POLL_INTERVAL cycles and reports pin toggles on a one-cycle change strobe.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (accepted when both high)
//   cmd_write              1 = write, 0 = read
//   cmd_address            target register
//   cmd_writedata          write data
//   rsp_valid              one-cycle read-response strobe
//   rsp_readdata           read data, held until the next response
//   pin_state              last polled value of address 0 (PIN_W LSBs)
//   pin_change             one-cycle strobe, new poll XOR previous poll
//   avm_*                  Avalon-MM initiator signals, all registered
// ----------------------------------------------------------------------------
module avm_gpio_initiator #(
    parameter int unsigned ADDR_W        = 2,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned PIN_W         = 2,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned POLL_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_readdata,

    output logic [PIN_W-1:0]  pin_state,
    output logic [PIN_W-1:0]  pin_change,

    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata
);

    // READ_LATENCY is 1..4, so the wait counter only ever holds 0..3.
    localparam int unsigned LAT_W  = 2;
    localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadAddr,
        StReadWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               src_poll_q, src_poll_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic               poll_pending_q, poll_pending_d;
    logic               first_poll_q, first_poll_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_readdata_q, rsp_readdata_d;
    logic [PIN_W-1:0]   pin_state_q, pin_state_d;
    logic [PIN_W-1:0]   pin_change_q, pin_change_d;

    logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
    logic               avm_chipselect_q, avm_chipselect_d;
    logic               avm_write_n_q, avm_write_n_d;
    logic [DATA_W-1:0]  avm_writedata_q, avm_writedata_d;

    logic               cmd_accept;

    // cmd_ready is registered and only ever high while sitting in IDLE.
    assign cmd_accept = cmd_valid && cmd_ready_q && (state_q == StIdle);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            src_poll_q       <= 1'b0;
            lat_cnt_q        <= '0;
            poll_cnt_q       <= '0;
            poll_pending_q   <= 1'b0;
            first_poll_q     <= 1'b1;
            cmd_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_readdata_q   <= '0;
            pin_state_q      <= '0;
            pin_change_q     <= '0;
            avm_address_q    <= '0;
            avm_chipselect_q <= 1'b0;
            avm_write_n_q    <= 1'b1;
            avm_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            src_poll_q       <= src_poll_d;
            lat_cnt_q        <= lat_cnt_d;
            poll_cnt_q       <= poll_cnt_d;
            poll_pending_q   <= poll_pending_d;
            first_poll_q     <= first_poll_d;
            cmd_ready_q      <= cmd_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_readdata_q   <= rsp_readdata_d;
            pin_state_q      <= pin_state_d;
            pin_change_q     <= pin_change_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_n_q    <= avm_write_n_d;
            avm_writedata_q  <= avm_writedata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        src_poll_d      = src_poll_q;
        lat_cnt_d       = lat_cnt_q;
        poll_cnt_d      = poll_cnt_q;
        poll_pending_d  = poll_pending_q;
        first_poll_d    = first_poll_q;
        rsp_valid_d     = 1'b0;
        rsp_readdata_d  = rsp_readdata_q;
        pin_state_d     = pin_state_q;
        pin_change_d    = '0;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;

        // Poll timer free-runs in every state. A wrap while a poll is already
        // pending just re-asserts the same flag, so polls never queue up.
        if (POLL_INTERVAL > 0) begin
            if (poll_cnt_q == POLL_LAST) begin
                poll_cnt_d     = '0;
                poll_pending_d = 1'b1;
            end else begin
                poll_cnt_d = poll_cnt_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                // A command always beats a pending poll; the poll waits for
                // the next IDLE cycle.
                if (cmd_accept) begin
                    avm_address_d = cmd_address;
                    src_poll_d    = 1'b0;
                    if (cmd_write) begin
                        avm_writedata_d = cmd_writedata;
                        state_d         = StWrite;
                    end else begin
                        state_d = StReadAddr;
                    end
                end else if (poll_pending_q) begin
                    avm_address_d = '0;
                    src_poll_d    = 1'b1;
                    // Launching clears the flag, even against a same-cycle
                    // wrap, so one expiry yields exactly one poll.
                    poll_pending_d = 1'b0;
                    state_d        = StReadAddr;
                end
            end

            StWrite: begin
                state_d = StDone;
            end

            StReadAddr: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = StReadWait;
            end

            StReadWait: begin
                // Counter hits 0 on the READ_LATENCY-th edge after the slave
                // saw the address phase: readdata is valid right now.
                if (lat_cnt_q == '0) begin
                    if (src_poll_q) begin
                        pin_state_d = avm_readdata[PIN_W-1:0];
                        if (first_poll_q) begin
                            first_poll_d = 1'b0;
                        end else begin
                            pin_change_d = avm_readdata[PIN_W-1:0] ^ pin_state_q;
                        end
                    end else begin
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = avm_readdata;
                    end
                    state_d = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up
        // with the state they belong to.
        cmd_ready_d      = (state_d == StIdle);
        avm_chipselect_d = (state_d == StWrite) || (state_d == StReadAddr);
        avm_write_n_d    = (state_d != StWrite);
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_readdata   = rsp_readdata_q;
    assign pin_state      = pin_state_q;
    assign pin_change     = pin_change_q;
    assign avm_address    = avm_address_q;
    assign avm_chipselect = avm_chipselect_q;
    assign avm_write_n    = avm_write_n_q;
    assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_avm_gpio_initiator.sv
// ----------------------------------------------------------------------------
// Testbench for avm_gpio_initiator.
// Instance a: READ_LATENCY=1, polling disabled.
// Instance b: READ_LATENCY=3, POLL_INTERVAL=16.
// Each instance talks to a small GPIO slave model (addr 0 = pins,
// addr 1 = direction register, fixed read latency).
// ----------------------------------------------------------------------------
module tb_avm_gpio_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance a ----------------
    logic        rst_a = 1'b1;
    logic        a_cmd_valid = 1'b0, a_cmd_write = 1'b0;
    logic [1:0]  a_cmd_address = '0;
    logic [31:0] a_cmd_writedata = '0;
    logic        a_cmd_ready, a_rsp_valid;
    logic [31:0] a_rsp_readdata;
    logic [1:0]  a_pin_state, a_pin_change;
    logic [1:0]  a_addr;
    logic        a_cs, a_wn;
    logic [31:0] a_wd, a_rd, a_mux;
    logic [1:0]  a_pins = 2'd0;
    logic [31:0] a_dir = 32'h0;
    logic [31:0] a_pipe [4];
    logic [3:0]  a_pv = '0;

    avm_gpio_initiator #(
        .ADDR_W(2), .DATA_W(32), .PIN_W(2), .READ_LATENCY(1), .POLL_INTERVAL(0)
    ) u_a (
        .clk(clk), .reset_n(rst_a),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
        .cmd_address(a_cmd_address), .cmd_writedata(a_cmd_writedata),
        .rsp_valid(a_rsp_valid), .rsp_readdata(a_rsp_readdata),
        .pin_state(a_pin_state), .pin_change(a_pin_change),
        .avm_address(a_addr), .avm_chipselect(a_cs), .avm_write_n(a_wn),
        .avm_writedata(a_wd), .avm_readdata(a_rd)
    );

    assign a_mux = (a_addr == 2'd0) ? {30'd0, a_pins} :
                   (a_addr == 2'd1) ? a_dir : 32'h0BAD_0BAD;
    assign a_rd  = a_pv[0] ? a_pipe[0] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        a_pv     <= {a_pv[2:0], a_cs & a_wn};
        a_pipe[0] <= a_mux;
        for (int i = 1; i < 4; i++) a_pipe[i] <= a_pipe[i-1];
        if (a_cs && !a_wn && a_addr == 2'd1) a_dir <= a_wd;
    end

    // ---------------- instance b ----------------
    logic        rst_b = 1'b1;
    logic        b_cmd_valid = 1'b0, b_cmd_write = 1'b0;
    logic [1:0]  b_cmd_address = '0;
    logic [31:0] b_cmd_writedata = '0;
    logic        b_cmd_ready, b_rsp_valid;
    logic [31:0] b_rsp_readdata;
    logic [1:0]  b_pin_state, b_pin_change;
    logic [1:0]  b_addr;
    logic        b_cs, b_wn;
    logic [31:0] b_wd, b_rd, b_mux;
    logic [1:0]  b_pins = 2'd0;
    logic [31:0] b_dir = 32'h0000_00C3;
    logic [31:0] b_pipe [4];
    logic [3:0]  b_pv = '0;

    avm_gpio_initiator #(
        .ADDR_W(2), .DATA_W(32), .PIN_W(2), .READ_LATENCY(3), .POLL_INTERVAL(16)
    ) u_b (
        .clk(clk), .reset_n(rst_b),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_address(b_cmd_address), .cmd_writedata(b_cmd_writedata),
        .rsp_valid(b_rsp_valid), .rsp_readdata(b_rsp_readdata),
        .pin_state(b_pin_state), .pin_change(b_pin_change),
        .avm_address(b_addr), .avm_chipselect(b_cs), .avm_write_n(b_wn),
        .avm_writedata(b_wd), .avm_readdata(b_rd)
    );

    assign b_mux = (b_addr == 2'd0) ? {30'd0, b_pins} :
                   (b_addr == 2'd1) ? b_dir : 32'h0BAD_0BAD;
    assign b_rd  = b_pv[2] ? b_pipe[2] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        b_pv     <= {b_pv[2:0], b_cs & b_wn};
        b_pipe[0] <= b_mux;
        for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
        if (b_cs && !b_wn && b_addr == 2'd1) b_dir <= b_wd;
    end

    // ---------------- helpers ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset b and release on a falling edge; the next rising edge is edge 1.
    task automatic reset_b();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        n_cmp++; if (a_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0h want 0", a_cmd_ready); end
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %0h want 0", a_rsp_valid); end
        n_cmp++; if (a_rsp_readdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_data: got %0h want 0", a_rsp_readdata); end
        n_cmp++; if ({a_pin_state, a_pin_change} !== 4'h0) begin n_err++; $display("FAIL rst_pins: got %0h want 0", {a_pin_state, a_pin_change}); end
        n_cmp++; if ({a_addr, a_cs, a_wn} !== 4'b0001) begin n_err++; $display("FAIL rst_avm: got %0b want 0001", {a_addr, a_cs, a_wn}); end
        n_cmp++; if (a_wd !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %0h want 0", a_wd); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        n_cmp++; if (a_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready0: got %0h want 0", a_cmd_ready); end
        wait_edges(1);
        n_cmp++; if (a_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready1: got %0h want 1", a_cmd_ready); end
    endtask

    task automatic test_write();
        a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_address = 2'd1; a_cmd_writedata = 32'h3;
        wait_edges(1);
        a_cmd_valid = 1'b0;
        n_cmp++; if ({a_cs, a_wn, a_addr} !== 4'b1001) begin n_err++; $display("FAIL wr_phase: got %0b want 1001", {a_cs, a_wn, a_addr}); end
        n_cmp++; if (a_wd !== 32'h3) begin n_err++; $display("FAIL wr_data: got %0h want 3", a_wd); end
        n_cmp++; if (a_cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_c1: got %0h want 0", a_cmd_ready); end
        wait_edges(1);
        n_cmp++; if ({a_cs, a_wn} !== 2'b01) begin n_err++; $display("FAIL wr_done_avm: got %0b want 01", {a_cs, a_wn}); end
        n_cmp++; if (a_cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_c2: got %0h want 0", a_cmd_ready); end
        n_cmp++; if (a_dir !== 32'h3) begin n_err++; $display("FAIL wr_slave_dir: got %0h want 3", a_dir); end
        wait_edges(1);
        n_cmp++; if (a_cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_c3: got %0h want 1", a_cmd_ready); end
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_no_rsp: got %0h want 0", a_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_address = 2'd1;
        for (int k = 0; k < 3; k++) begin
            a_cmd_writedata = 32'h10 + k;
            wait_edges(1);
            if (k == 2) a_cmd_valid = 1'b0;
            n_cmp++; if ({a_cs, a_wn} !== 2'b10 || a_wd !== 32'h10 + k) begin
                n_err++; $display("FAIL b2b_write%0d: got cs/wn %0b data %0h want 10 / %0h", k, {a_cs, a_wn}, a_wd, 32'h10 + k);
            end
            n_cmp++; if (a_cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy%0d: got %0h want 0", k, a_cmd_ready); end
            wait_edges(2);
            n_cmp++; if (a_cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %0h want 1", k, a_cmd_ready); end
        end
        n_cmp++; if (a_dir !== 32'h12) begin n_err++; $display("FAIL b2b_dir: got %0h want 12", a_dir); end
    endtask

    task automatic test_read_lat1();
        a_pins = 2'd2;
        a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_address = 2'd0;
        wait_edges(1);
        a_cmd_valid = 1'b0;
        n_cmp++; if ({a_cs, a_wn, a_addr} !== 4'b1100) begin n_err++; $display("FAIL rd1_phase: got %0b want 1100", {a_cs, a_wn, a_addr}); end
        wait_edges(1);
        n_cmp++; if ({a_cs, a_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL rd1_wait: got %0b want 00", {a_cs, a_rsp_valid}); end
        wait_edges(1);
        n_cmp++; if (a_rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd1_rsp_valid: got %0h want 1", a_rsp_valid); end
        n_cmp++; if (a_rsp_readdata !== 32'h2) begin n_err++; $display("FAIL rd1_rsp_data: got %0h want 2", a_rsp_readdata); end
        n_cmp++; if (a_pin_state !== 2'd0) begin n_err++; $display("FAIL rd1_pin_untouched: got %0h want 0", a_pin_state); end
        wait_edges(1);
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd1_rsp_pulse: got %0h want 0", a_rsp_valid); end
        n_cmp++; if (a_rsp_readdata !== 32'h2) begin n_err++; $display("FAIL rd1_rsp_hold: got %0h want 2", a_rsp_readdata); end
        n_cmp++; if (a_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rd1_ready: got %0h want 1", a_cmd_ready); end
        a_cmd_valid = 1'b1; a_cmd_address = 2'd1;
        wait_edges(1);
        a_cmd_valid = 1'b0;
        wait_edges(2);
        n_cmp++; if ({a_rsp_valid, a_rsp_readdata} !== {1'b1, 32'h12}) begin
            n_err++; $display("FAIL rd1_dir: got %0h/%0h want 1/12", a_rsp_valid, a_rsp_readdata);
        end
    endtask

    task automatic test_idle_no_poll();
        int act = 0;
        for (int i = 0; i < 10000; i++) begin
            wait_edges(1);
            if (a_cs !== 1'b0 || a_wn !== 1'b1) act++;
        end
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL idle_activity: got %0d cycles want 0", act); end
    endtask

    task automatic test_read_lat3();
        b_pins = 2'd1;
        reset_b();
        wait_edges(1);
        n_cmp++; if (b_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rd3_ready0: got %0h want 1", b_cmd_ready); end
        b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_address = 2'd1;
        wait_edges(1);
        b_cmd_address = 2'd0;
        n_cmp++; if ({b_cs, b_wn, b_addr} !== 4'b1101) begin n_err++; $display("FAIL rd3_phase: got %0b want 1101", {b_cs, b_wn, b_addr}); end
        for (int i = 1; i <= 3; i++) begin
            wait_edges(1);
            n_cmp++; if ({b_rsp_valid, b_cmd_ready} !== 2'b00) begin
                n_err++; $display("FAIL rd3_wait%0d: got %0b want 00", i, {b_rsp_valid, b_cmd_ready});
            end
        end
        wait_edges(1);
        n_cmp++; if ({b_rsp_valid, b_rsp_readdata} !== {1'b1, 32'hC3}) begin
            n_err++; $display("FAIL rd3_rsp: got %0h/%0h want 1/c3", b_rsp_valid, b_rsp_readdata);
        end
        wait_edges(1);
        n_cmp++; if ({b_cmd_ready, b_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL rd3_idle: got %0b want 10", {b_cmd_ready, b_rsp_valid}); end
        wait_edges(1);
        b_cmd_valid = 1'b0;
        n_cmp++; if ({b_cs, b_addr} !== 3'b100) begin n_err++; $display("FAIL rd3_second_phase: got %0b want 100", {b_cs, b_addr}); end
        wait_edges(4);
        n_cmp++; if ({b_rsp_valid, b_rsp_readdata} !== {1'b1, 32'h1}) begin
            n_err++; $display("FAIL rd3_second_rsp: got %0h/%0h want 1/1", b_rsp_valid, b_rsp_readdata);
        end
        wait_edges(1);
    endtask

    task automatic test_reset_midread();
        int seen = 0;
        b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_address = 2'd1;
        wait_edges(1);
        b_cmd_valid = 1'b0;
        wait_edges(2);
        n_cmp++; if ({b_cs, b_rsp_valid, b_cmd_ready} !== 3'b000) begin
            n_err++; $display("FAIL mr_in_wait: got %0b want 000", {b_cs, b_rsp_valid, b_cmd_ready});
        end
        rst_b = 1'b0;
        #1;
        n_cmp++; if (b_rsp_readdata !== 32'h0) begin n_err++; $display("FAIL mr_rsp_data: got %0h want 0", b_rsp_readdata); end
        n_cmp++; if ({b_addr, b_cs, b_wn, b_cmd_ready, b_rsp_valid} !== 6'b000100) begin
            n_err++; $display("FAIL mr_outputs: got %0b want 000100", {b_addr, b_cs, b_wn, b_cmd_ready, b_rsp_valid});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        n_cmp++; if (b_cmd_ready !== 1'b0) begin n_err++; $display("FAIL mr_rel_ready0: got %0h want 0", b_cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            wait_edges(1);
            if (b_rsp_valid !== 1'b0) seen++;
            if (i == 0) begin
                n_cmp++; if (b_cmd_ready !== 1'b1) begin n_err++; $display("FAIL mr_rel_ready1: got %0h want 1", b_cmd_ready); end
            end
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mr_stale_rsp: got %0d want 0", seen); end
    endtask

    task automatic test_polling();
        b_pins = 2'd2;
        reset_b();
        wait_edges(17);
        n_cmp++; if ({b_cs, b_wn, b_addr, b_cmd_ready} !== 5'b11000) begin
            n_err++; $display("FAIL poll1_phase: got %0b want 11000", {b_cs, b_wn, b_addr, b_cmd_ready});
        end
        wait_edges(4);
        n_cmp++; if ({b_pin_state, b_pin_change} !== 4'b1000) begin
            n_err++; $display("FAIL poll1_first: got %0h/%0h want 2/0", b_pin_state, b_pin_change);
        end
        n_cmp++; if (b_rsp_valid !== 1'b0) begin n_err++; $display("FAIL poll1_no_rsp: got %0h want 0", b_rsp_valid); end
        b_pins = 2'd3;
        wait_edges(16);
        n_cmp++; if ({b_pin_state, b_pin_change} !== 4'b1101) begin
            n_err++; $display("FAIL poll2_change: got %0h/%0h want 3/1", b_pin_state, b_pin_change);
        end
        wait_edges(1);
        n_cmp++; if ({b_pin_state, b_pin_change} !== 4'b1100) begin
            n_err++; $display("FAIL poll2_pulse: got %0h/%0h want 3/0", b_pin_state, b_pin_change);
        end
        b_pins = 2'd0;
        wait_edges(15);
        n_cmp++; if ({b_pin_state, b_pin_change} !== 4'b0011) begin
            n_err++; $display("FAIL poll3_change: got %0h/%0h want 0/3", b_pin_state, b_pin_change);
        end
    endtask

    task automatic test_collision();
        b_pins = 2'd1;
        reset_b();
        wait_edges(16);
        n_cmp++; if (b_cmd_ready !== 1'b1) begin n_err++; $display("FAIL col_ready: got %0h want 1", b_cmd_ready); end
        b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_address = 2'd1;
        wait_edges(1);
        b_cmd_valid = 1'b0;
        n_cmp++; if ({b_cs, b_addr} !== 3'b101) begin n_err++; $display("FAIL col_cmd_first: got %0b want 101", {b_cs, b_addr}); end
        wait_edges(4);
        n_cmp++; if ({b_rsp_valid, b_rsp_readdata} !== {1'b1, 32'hC3}) begin
            n_err++; $display("FAIL col_cmd_rsp: got %0h/%0h want 1/c3", b_rsp_valid, b_rsp_readdata);
        end
        wait_edges(1);
        n_cmp++; if ({b_cs, b_cmd_ready} !== 2'b01) begin n_err++; $display("FAIL col_idle: got %0b want 01", {b_cs, b_cmd_ready}); end
        wait_edges(1);
        n_cmp++; if ({b_cs, b_wn, b_addr} !== 4'b1100) begin n_err++; $display("FAIL col_poll_phase: got %0b want 1100", {b_cs, b_wn, b_addr}); end
        wait_edges(4);
        n_cmp++; if ({b_pin_state, b_pin_change, b_rsp_valid} !== 5'b01000) begin
            n_err++; $display("FAIL col_poll_result: got %0b want 01000", {b_pin_state, b_pin_change, b_rsp_valid});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_read_lat1();
        test_idle_no_poll();
        test_read_lat3();
        test_reset_midread();
        test_polling();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
